// File: rtl/rf_param_if.sv
// Decode/writeback bus for rf_param: clear request, ready flag, one write port
// and two combinational read ports.
interface rf_param_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              clr;
    logic              ready;
    logic              RegWrite;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [ADDR_W-1:0] rc;
    logic [DATA_W-1:0] dc;
    logic [DATA_W-1:0] da;
    logic [DATA_W-1:0] db;

    modport master (
        output clr, RegWrite, ra, rb, rc, dc,
        input  ready, da, db
    );

    modport slave (
        input  clr, RegWrite, ra, rb, rc, dc,
        output ready, da, db
    );
endinterface

// File: rtl/rf_param.sv
// Parametrised 2R/1W register file with a hardware clear sweep after reset or clr.
// Optional same-cycle write-to-read bypass when RF_BYPASS_EN is defined.
module rf_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    rf_param_if.slave bus
);

    localparam int unsigned NREG = 2**ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ready_q;
    logic              wr_en_c;
    logic [DATA_W-1:0] mem [NREG];

    // State, clear pointer and ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= (state_d == RUN);
        end
    end

    // Next state: sweep ends on the last index, clr always restarts the sweep
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            INIT: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == '1) state_d = RUN;
            end
            RUN: begin
                state_d = RUN;
            end
        endcase
        if (bus.clr) begin
            state_d = INIT;
            ptr_d   = '0;
        end
    end

    assign wr_en_c = (state_q == RUN) && bus.RegWrite && !bus.clr &&
                     !(ZERO_REG && (bus.rc == '0));

    // Array: the sweep owns the write port during INIT
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem[ptr_q] <= '0;
        end else if (wr_en_c) begin
            mem[bus.rc] <= bus.dc;
        end
    end

    function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
        logic byp;
`ifdef RF_BYPASS_EN
        byp = wr_en_c && (a == bus.rc);
`else
        byp = 1'b0;
`endif
        if (state_q != RUN)                 rd_port = '0;
        else if (ZERO_REG && (a == '0))     rd_port = '0;
        else if (byp)                       rd_port = bus.dc;
        else                                rd_port = mem[a];
    endfunction

    always_comb begin
        bus.da = rd_port(bus.ra);
        bus.db = rd_port(bus.rb);
    end

    assign bus.ready = ready_q;

endmodule

// File: tb/tb_rf_param.sv
// Directed bench for rf_param: expected values queued at stimulus, popped at sampling.
// Runs a ZERO_REG=1 and a ZERO_REG=0 instance side by side on the same inputs.
module tb_rf_param;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_param_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
    rf_param_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();

    rf_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    rf_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus1.clr      = bus0.clr;
    assign bus1.RegWrite = bus0.RegWrite;
    assign bus1.ra       = bus0.ra;
    assign bus1.rb       = bus0.rb;
    assign bus1.rc       = bus0.rc;
    assign bus1.dc       = bus0.dc;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb[$];
    int  nvec = 0;
    int  nerr = 0;
    int  ncyc;
    logic [31:0] byp_exp;
    logic [31:0] zbyp_exp;

    task automatic expect_v(input string tag, input logic [31:0] v);
        sb_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        sb_t e;
        if (sb.size() == 0) begin
            nerr++;
            $error("FAIL sb_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            nvec++;
            assert (obs === e.exp) else begin
                nerr++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus0.ready && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus0.RegWrite = 1'b1;
        bus0.rc       = a;
        bus0.dc       = d;
        tick();
        bus0.RegWrite = 1'b0;
    endtask

    initial begin
`ifdef RF_BYPASS_EN
        byp_exp  = 32'hA5A5_A5A5;
        zbyp_exp = 32'hCAFE_0000;
`else
        byp_exp  = 32'h0000_0011;
        zbyp_exp = 32'h1234_5678;
`endif
        bus0.clr = 1'b0; bus0.RegWrite = 1'b0;
        bus0.ra = '0; bus0.rb = '0; bus0.rc = '0; bus0.dc = '0;

        // Reset and initial sweep
        repeat (3) @(posedge clk);
        #1;
        expect_v("rst_ready", 32'd0); chk(32'(bus0.ready));
        rst_n = 1'b1;
        bus0.ra = 5'd31; bus0.rb = 5'd1;
        #1;
        expect_v("init_da", 32'd0); chk(bus0.da);
        expect_v("init_db", 32'd0); chk(bus0.db);
        wait_ready(ncyc);
        expect_v("init_len", 32'd32); chk(32'(ncyc));
        for (int i = 0; i < 32; i++) begin
            bus0.ra = 5'(i); bus0.rb = 5'(31 - i);
            #1;
            expect_v("init_rd_a", 32'd0); chk(bus0.da);
            expect_v("init_rd_b", 32'd0); chk(bus0.db);
            expect_v("init_rd_z0", 32'd0); chk(bus1.da);
        end
        tick();

        // Basic write then read
        wr(5'd5, 32'hDEAD_BEEF);
        bus0.ra = 5'd5; bus0.rb = 5'd6;
        #1;
        expect_v("wr5_da", 32'hDEAD_BEEF); chk(bus0.da);
        expect_v("rd6_db", 32'd0);         chk(bus0.db);

        // Zero register, both configurations
        tick();
        wr(5'd0, 32'h1234_5678);
        bus0.ra = 5'd0; bus0.rb = 5'd0;
        #1;
        expect_v("zr1_da", 32'd0);         chk(bus0.da);
        expect_v("zr0_da", 32'h1234_5678); chk(bus1.da);
        expect_v("zr0_db", 32'h1234_5678); chk(bus1.db);

        // Same-cycle write/read of reg 7
        tick();
        wr(5'd7, 32'h0000_0011);
        bus0.RegWrite = 1'b1; bus0.rc = 5'd7; bus0.dc = 32'hA5A5_A5A5;
        bus0.ra = 5'd7; bus0.rb = 5'd7;
        #1;
        expect_v("byp_da", byp_exp); chk(bus0.da);
        expect_v("byp_db", byp_exp); chk(bus0.db);
        tick();
        bus0.RegWrite = 1'b0;
        #1;
        expect_v("post_byp_da", 32'hA5A5_A5A5); chk(bus0.da);

        // Zero-register rule beats bypass
        tick();
        bus0.RegWrite = 1'b1; bus0.rc = 5'd0; bus0.dc = 32'hCAFE_0000;
        bus0.ra = 5'd0; bus0.rb = 5'd0;
        #1;
        expect_v("zr1_byp_da", 32'd0); chk(bus0.da);
        expect_v("zr0_byp_da", zbyp_exp); chk(bus1.da);
        tick();
        bus0.RegWrite = 1'b0;

        // Clear sweep: clr beats the simultaneous write, writes ignored in INIT
        wr(5'd3, 32'h33);
        wr(5'd31, 32'hFF);
        wr(5'd2, 32'h22);
        bus0.clr = 1'b1; bus0.RegWrite = 1'b1; bus0.rc = 5'd4; bus0.dc = 32'h44;
        tick();
        bus0.clr = 1'b0;
        bus0.rc = 5'd2; bus0.dc = 32'hBAD0_0BAD; bus0.ra = 5'd3;
        #1;
        expect_v("clr_ready", 32'd0); chk(32'(bus0.ready));
        expect_v("clr_da",    32'd0); chk(bus0.da);
        wait_ready(ncyc);
        bus0.RegWrite = 1'b0;
        expect_v("clr_len", 32'd32); chk(32'(ncyc));
        bus0.ra = 5'd3; bus0.rb = 5'd4;
        #1;
        expect_v("clr_r3", 32'd0); chk(bus0.da);
        expect_v("clr_r4", 32'd0); chk(bus0.db);
        bus0.ra = 5'd31; bus0.rb = 5'd2;
        #1;
        expect_v("clr_r31", 32'd0); chk(bus0.da);
        expect_v("clr_r2",  32'd0); chk(bus0.db);
        tick();

        // Reset in the middle of a sweep
        wr(5'd20, 32'h20);
        wr(5'd9, 32'h99);
        bus0.clr = 1'b1;
        tick();
        bus0.clr = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_ready(ncyc);
        expect_v("mid_rst_len", 32'd32); chk(32'(ncyc));
        for (int i = 0; i < 32; i++) begin
            bus0.ra = 5'(i); bus0.rb = 5'(i);
            #1;
            expect_v("mid_rst_rd", 32'd0); chk(bus0.da);
            expect_v("mid_rst_same", 32'd0); chk(bus0.db);
        end

        if (sb.size() != 0) begin
            nerr++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
